// File: rtl/nxs_keccak_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nxs_keccak_pkg
// Description : Shared widths, default pipeline latency and the feeder FSM
//               state encoding for the Nexus Keccak-1024 work feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package nxs_keccak_pkg;

    localparam int HASH_LATENCY_DEF = 72;
    localparam int HDR_W            = 960;
    localparam int NONCE_W          = 64;
    localparam int STATE_W          = 1024;
    localparam int RES_W            = 2 * NONCE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feeder_state_e;

endpackage : nxs_keccak_pkg
`default_nettype wire

// File: rtl/nxs_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nxs_result_fifo
// Description : Synchronous FIFO holding {nonce, hash} hit records. A push is
//               accepted while full when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module nxs_result_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] pop_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_ptr_one = (AW + 1)'(1);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic w_wr_en;
    logic w_rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_rd_en = pop_i && !empty_o;
    // When full, the slot being written is the one being popped this cycle.
    assign w_wr_en = push_i && (!full_o || w_rd_en);

    // Output is forced to zero while empty so a reset leaves no stale record visible.
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_wr_en) wr_ptr_q <= wr_ptr_q + c_ptr_one;
            if (w_rd_en) rd_ptr_q <= rd_ptr_q + c_ptr_one;
        end
    end

    // Storage write; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule : nxs_result_fifo
`default_nettype wire

// File: rtl/nxs_keccak_work_feeder.sv
`default_nettype none
// ============================================================================
// Module      : nxs_keccak_work_feeder
// Description : Issues one Keccak-1024 input state per clock with an
//               incrementing nonce, tracks in-flight nonces with 1-bit tags
//               across the pipeline latency, compares returned hash words to
//               the job target and queues hits on a valid/ready port.
//               Define NXS_FEEDER_STATS_EN to build the hash/drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
module nxs_keccak_work_feeder
    import nxs_keccak_pkg::*;
#(
    parameter int HASH_LATENCY   = HASH_LATENCY_DEF,
    parameter int RES_FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               work_valid_i,
    output logic               work_ready_o,
    input  logic [HDR_W-1:0]   work_header_i,
    input  logic [NONCE_W-1:0] work_nonce_i,
    input  logic [31:0]        work_count_i,
    input  logic [63:0]        work_target_i,
    input  logic               abort_i,
    output logic [STATE_W-1:0] hash_state_o,
    input  logic [63:0]        hash_out_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [NONCE_W-1:0] res_nonce_o,
    output logic [63:0]        res_hash_o,
    output logic               busy_o,
    output logic [47:0]        hash_cnt_o,
    output logic [15:0]        drop_cnt_o
);

    feeder_state_e             state_q;
    logic [HDR_W-1:0]          hdr_q;
    logic [63:0]               target_q;
    logic [NONCE_W-1:0]        iss_nonce_q;
    logic [NONCE_W-1:0]        ret_nonce_q;
    logic [31:0]               remaining_q;
    logic [STATE_W-1:0]        hash_state_q;
    // hash_state_q holds a live nonce this cycle; the pipeline samples it at the next edge.
    logic                      hs_valid_q;
    logic [HASH_LATENCY-1:0]   tags_q;

    logic w_accept;
    logic w_issue;
    logic w_retire;
    logic w_hit;
    logic w_pop;
    logic w_push;
    logic w_fifo_full;
    logic w_fifo_empty;

    assign w_accept = (state_q == IDLE) && work_valid_i;
    assign w_issue  = (state_q == RUN) && !abort_i;
    // An abort kills whatever is retiring in the same cycle.
    assign w_retire = tags_q[HASH_LATENCY-1] && !abort_i;
    assign w_hit    = w_retire && (hash_out_i <= target_q);
    assign w_pop    = res_valid_o && res_ready_i;
    assign w_push   = w_hit && (!w_fifo_full || w_pop);

    assign work_ready_o = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign hash_state_o = hash_state_q;
    assign res_valid_o  = !w_fifo_empty;

    // Job FSM: latch job, issue one nonce per clock, drain in-flight tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hdr_q        <= '0;
            target_q     <= '0;
            iss_nonce_q  <= '0;
            remaining_q  <= '0;
            hash_state_q <= '0;
            hs_valid_q   <= 1'b0;
        end else begin
            hs_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (work_valid_i) begin
                        hdr_q       <= work_header_i;
                        target_q    <= work_target_i;
                        iss_nonce_q <= work_nonce_i;
                        remaining_q <= work_count_i;
                        state_q     <= (work_count_i == 32'd0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else begin
                        hash_state_q <= {iss_nonce_q, hdr_q};
                        hs_valid_q   <= 1'b1;
                        iss_nonce_q  <= iss_nonce_q + 64'd1;
                        remaining_q  <= remaining_q - 32'd1;
                        if (remaining_q == 32'd1) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort_i || (!hs_valid_q && (tags_q == '0))) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag shift register and retire-side nonce; nonces retire in issue order.
    always_ff @(posedge clk) begin
        if (rst) begin
            tags_q      <= '0;
            ret_nonce_q <= '0;
        end else if (w_accept) begin
            tags_q      <= {tags_q[HASH_LATENCY-2:0], hs_valid_q};
            ret_nonce_q <= work_nonce_i;
        end else if (abort_i) begin
            tags_q      <= '0;
        end else begin
            tags_q      <= {tags_q[HASH_LATENCY-2:0], hs_valid_q};
            if (w_retire) ret_nonce_q <= ret_nonce_q + 64'd1;
        end
    end

    nxs_result_fifo #(
        .DATA_W (RES_W),
        .DEPTH  (RES_FIFO_DEPTH)
    ) u_res_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i ({ret_nonce_q, hash_out_i}),
        .pop_i       (w_pop),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .pop_data_o  ({res_nonce_o, res_hash_o})
    );

`ifdef NXS_FEEDER_STATS_EN
    logic [47:0] hash_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        w_drop;

    assign w_drop     = w_hit && !w_push;
    assign hash_cnt_o = hash_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

    // Statistics: wrapping issue count, saturating drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            hash_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (w_issue) hash_cnt_q <= hash_cnt_q + 48'd1;
            if (w_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`else
    logic w_issue_unused;
    assign w_issue_unused = w_issue;
    assign hash_cnt_o     = '0;
    assign drop_cnt_o     = '0;
`endif

endmodule : nxs_keccak_work_feeder
`default_nettype wire

// File: tb/tb_nxs_keccak_work_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nxs_keccak_work_feeder
// Description : Directed bench for the work feeder. A HASH_LATENCY-stage
//               delay line returns hash = nonce ^ mix; expected hits go to a
//               scoreboard queue when a job is driven and are popped when the
//               DUT hands a result over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nxs_keccak_work_feeder;
    import nxs_keccak_pkg::*;

    localparam int L     = 72;
    localparam int DEPTH = 4;
`ifdef NXS_FEEDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [63:0] MAXT = 64'hFFFF_FFFF_FFFF_FFFF;

    logic               clk = 1'b0;
    logic               rst;
    logic               work_valid;
    logic               work_ready;
    logic [HDR_W-1:0]   work_header;
    logic [63:0]        work_nonce;
    logic [31:0]        work_count;
    logic [63:0]        work_target;
    logic               abort;
    logic [STATE_W-1:0] hash_state;
    logic [63:0]        hash_out;
    logic               res_valid;
    logic               res_ready;
    logic [63:0]        res_nonce;
    logic [63:0]        res_hash;
    logic               busy;
    logic [47:0]        hash_cnt;
    logic [15:0]        drop_cnt;

    logic [63:0]        mix;
    logic [63:0]        pipe_q [L];
    logic [127:0]       sb_q [$];
    int                 n_assert = 0;
    int                 n_fail   = 0;

    always #5 clk = ~clk;

    nxs_keccak_work_feeder #(
        .HASH_LATENCY   (L),
        .RES_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .work_valid_i  (work_valid),
        .work_ready_o  (work_ready),
        .work_header_i (work_header),
        .work_nonce_i  (work_nonce),
        .work_count_i  (work_count),
        .work_target_i (work_target),
        .abort_i       (abort),
        .hash_state_o  (hash_state),
        .hash_out_i    (hash_out),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_nonce_o   (res_nonce),
        .res_hash_o    (res_hash),
        .busy_o        (busy),
        .hash_cnt_o    (hash_cnt),
        .drop_cnt_o    (drop_cnt)
    );

    // Pipeline model: hash_out is the word for the state presented L clocks earlier.
    always @(posedge clk) begin
        pipe_q[0] <= hash_state[1023:960] ^ mix;
        for (int i = 1; i < L; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign hash_out = pipe_q[L-1];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every handed-over result must be the next expected hit.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            n_assert++;
            assert (sb_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_result observed=%0h expected=none", res_nonce);
            end
            if (sb_q.size() > 0) chk("res_entry", {res_nonce, res_hash}, sb_q.pop_front());
        end
    end

    task automatic push_expected(input logic [63:0] start, input int count,
                                 input logic [63:0] target, input int max_push);
        int pushed = 0;
        for (int i = 0; i < count; i++) begin
            logic [63:0] n;
            logic [63:0] h;
            n = start + 64'(i);
            h = n ^ mix;
            if (h <= target && pushed < max_push) begin
                sb_q.push_back({n, h});
                pushed++;
            end
        end
    endtask

    task automatic start_job(input logic [63:0] n, input logic [31:0] c,
                             input logic [63:0] t, input logic ab);
        @(negedge clk);
        chk("work_ready_before_job", 128'(work_ready), 128'(1));
        work_valid  = 1'b1;
        work_nonce  = n;
        work_count  = c;
        work_target = t;
        abort       = ab;
        @(negedge clk);
        work_valid  = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("job_done_busy", 128'(busy), 128'(0));
    endtask

    task automatic wait_sb(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    endtask

    initial begin
        int k;
        rst         = 1'b1;
        work_valid  = 1'b0;
        work_header = {15{64'hDEAD_BEEF_0BAD_F00D}};
        work_nonce  = '0;
        work_count  = '0;
        work_target = '0;
        abort       = 1'b0;
        res_ready   = 1'b1;
        mix         = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_work_ready", 128'(work_ready), 128'(1));
        chk("rst_res_valid",  128'(res_valid),  128'(0));
        chk("rst_busy",       128'(busy),       128'(0));
        chk("rst_hash_state", 128'(|hash_state), 128'(0));
        chk("rst_hash_cnt",   128'(hash_cnt),   128'(0));
        chk("rst_drop_cnt",   128'(drop_cnt),   128'(0));
        rst = 1'b0;

        // Job 1: 8 nonces from 0x10, all hit; first result latency
        mix = 64'hA5A5_5A5A_0F0F_F0F0;
        push_expected(64'h10, 8, MAXT, 100);
        start_job(64'h10, 32'd8, MAXT, 1'b0);
        k = 0;
        while (hash_state[1023:960] !== 64'h10 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("first_issue_nonce",  128'(hash_state[1023:960]), 128'(64'h10));
        chk("first_issue_header", 128'(hash_state[127:0]), {2{64'hDEAD_BEEF_0BAD_F00D}});
        // Pipeline samples one clock after presentation; the hit is registered into
        // the result FIFO one clock after hash_out shows it.
        k = 0;
        while (!res_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("first_result_latency", 128'(k), 128'(L + 1));
        wait_idle(200);
        wait_sb(50);
        chk("hash_cnt_job1", 128'(hash_cnt), STATS ? 128'(8) : 128'(0));

        // Job 2: hash = nonce, target 5; equality is a hit
        mix = '0;
        push_expected(64'h3, 6, 64'h5, 100);
        start_job(64'h3, 32'd6, 64'h5, 1'b0);
        wait_idle(200);
        wait_sb(50);

        // Job 3: result port stalled, 10 hits into a 4-deep FIFO
        res_ready = 1'b0;
        push_expected(64'h100, 10, MAXT, DEPTH);
        start_job(64'h100, 32'd10, MAXT, 1'b0);
        wait_idle(200);
        chk("stall_res_valid", 128'(res_valid), 128'(1));
        chk("stall_res_nonce", 128'(res_nonce), 128'(64'h100));
        repeat (5) @(negedge clk);
        chk("stall_res_stable", {res_nonce, res_hash}, {64'h100, 64'h100});
        chk("drop_cnt", 128'(drop_cnt), STATS ? 128'(6) : 128'(0));
        res_ready = 1'b1;
        wait_sb(50);

        // Job 4: nonce wrap
        push_expected(64'hFFFF_FFFF_FFFF_FFFE, 4, MAXT, 100);
        start_job(64'hFFFF_FFFF_FFFF_FFFE, 32'd4, MAXT, 1'b0);
        wait_idle(200);
        wait_sb(50);

        // Job 5: abort after 20 of 100 issues
        start_job(64'h1000, 32'd100, MAXT, 1'b0);
        k = 0;
        while (hash_state[1023:960] !== 64'h1013 && k < 40) begin
            @(negedge clk);
            k++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",       128'(busy),       128'(0));
        chk("abort_work_ready", 128'(work_ready), 128'(1));
        chk("abort_hash_state_hold", 128'(hash_state[1023:960]), 128'(64'h1013));
        chk("abort_hash_cnt", 128'(hash_cnt), STATS ? 128'(48) : 128'(0));
        repeat (L + 10) @(negedge clk);
        chk("abort_no_results", 128'(res_valid), 128'(0));

        // Job 6: abort coinciding with accept is ignored
        push_expected(64'h2000, 3, MAXT, 100);
        start_job(64'h2000, 32'd3, MAXT, 1'b1);
        wait_idle(200);
        wait_sb(50);
        chk("hash_cnt_job6", 128'(hash_cnt), STATS ? 128'(51) : 128'(0));

        // Reset mid-run with two hits queued
        res_ready = 1'b0;
        start_job(64'h3000, 32'd50, MAXT, 1'b0);
        k = 0;
        while (!res_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("pre_rst_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_res_valid",  128'(res_valid),  128'(0));
        chk("midrst_busy",       128'(busy),       128'(0));
        chk("midrst_work_ready", 128'(work_ready), 128'(1));
        chk("midrst_hash_state", 128'(|hash_state), 128'(0));
        chk("midrst_hash_cnt",   128'(hash_cnt),   128'(0));
        chk("midrst_drop_cnt",   128'(drop_cnt),   128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fifo_empty", 128'(res_valid), 128'(0));

        // Job after reset
        res_ready = 1'b1;
        push_expected(64'h4000, 2, MAXT, 100);
        start_job(64'h4000, 32'd2, MAXT, 1'b0);
        wait_idle(200);
        wait_sb(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_nxs_keccak_work_feeder
`default_nettype wire
